// File: rtl/vector_mem_unit.sv
// vector_mem_unit: multi-cycle strided vector load/store engine between the
// scalar data RAM port and the vector register file. Loads stage lanes
// internally and publish the whole vector at once. Stores stream the lanes
// captured when the request was accepted.
module vector_mem_unit #(
  parameter int DATA_W = 16,
  parameter int LANES  = 8,
  parameter int ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mode,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W-1:0]       stride,
  input  logic [LANES*DATA_W-1:0] vec_in,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    mem_wren,
  output logic [LANES*DATA_W-1:0] vec_out,
  output logic                    busy,
  output logic                    done
);

  localparam int KW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LD, S_LD_LAST, S_ST, S_DONE} state_e;

  state_e                          state_q, state_d;
  logic [KW-1:0]                   k_q, k_d;
  logic [ADDR_W-1:0]               addr_q, addr_d;
  logic [ADDR_W-1:0]               stride_q, stride_d;
  logic [LANES-1:0][DATA_W-1:0]    vec_q, vec_d;
  logic [LANES-1:0][DATA_W-1:0]    stage_q, stage_d;
  logic [LANES-1:0][DATA_W-1:0]    vout_q, vout_d;
  logic                            k_last;

  assign k_last = (k_q == KW'(LANES-1));

  // Next-state logic: lane counter, address accumulator, staging and result.
  // The load/store choice is carried by the state itself, so mode needs no
  // separate register once accepted.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    vec_d    = vec_q;
    stage_d  = stage_q;
    vout_d   = vout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          stride_d = stride;
          vec_d    = vec_in;
          k_d      = '0;
          addr_d   = base_addr;
          state_d  = mode ? S_ST : S_LD;
        end
      end
      S_LD: begin
        // RAM data lags the address by one cycle, so lane k-1 lands now.
        if (k_q != '0) stage_d[k_q - KW'(1)] = mem_rdata;
        if (k_last) begin
          state_d = S_LD_LAST;
        end else begin
          k_d    = k_q + KW'(1);
          addr_d = addr_q + stride_q;
        end
      end
      S_LD_LAST: begin
        // Last lane arrives; publish the complete vector in one step.
        stage_d[LANES-1] = mem_rdata;
        vout_d           = stage_q;
        vout_d[LANES-1]  = mem_rdata;
        state_d          = S_DONE;
      end
      S_ST: begin
        if (k_last) begin
          state_d = S_DONE;
        end else begin
          k_d    = k_q + KW'(1);
          addr_d = addr_q + stride_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any operation and clears the result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      addr_q   <= '0;
      stride_q <= '0;
      vec_q    <= '0;
      stage_q  <= '0;
      vout_q   <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      vec_q    <= vec_d;
      stage_q  <= stage_d;
      vout_q   <= vout_d;
    end
  end

  // Outputs decoded from state; the RAM port is only driven while busy.
  always_comb begin
    busy      = (state_q == S_LD) || (state_q == S_LD_LAST) || (state_q == S_ST);
    done      = (state_q == S_DONE);
    mem_wren  = (state_q == S_ST);
    mem_addr  = busy ? addr_q : '0;
    mem_wdata = (state_q == S_ST) ? vec_q[k_q] : '0;
  end

  assign vec_out = vout_q;

endmodule

// File: tb/tb_vector_mem_unit.sv
// Directed bench for vector_mem_unit with a registered-address RAM model.
module tb_vector_mem_unit;
  localparam int DW = 16, LN = 8, AW = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic [AW-1:0]    base_addr = '0;
  logic [AW-1:0]    stride = '0;
  logic [LN*DW-1:0] vec_in = '0;
  logic [DW-1:0]    mem_rdata = '0;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             mem_wren;
  logic [LN*DW-1:0] vec_out;
  logic             busy;
  logic             done;

  int checks = 0;
  int failures = 0;
  logic [LN*DW-1:0] cur_exp = '0;

  logic [DW-1:0] ram [0:65535];

  vector_mem_unit #(.DATA_W(DW), .LANES(LN), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .base_addr(base_addr), .stride(stride), .vec_in(vec_in),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wren(mem_wren), .vec_out(vec_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Registered-address RAM: q reflects the address presented last edge.
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic          m;
    logic [15:0]   base;
    logic [15:0]   strd;
    logic [127:0]  vin;
    logic [127:0]  exp_vout;
    logic [15:0]   chk_a;
    logic [15:0]   chk_d;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask

  // Issue one operation and follow it cycle by cycle until done.
  task automatic run_op(input vec_t v, input bit disturb);
    logic [15:0] ea, ea_last;
    int nb;
    bit seen;
    @(negedge clk);
    start = 1'b1; mode = v.m; base_addr = v.base; stride = v.strd; vec_in = v.vin;
    @(posedge clk); #1 start = 1'b0;
    ea = v.base; ea_last = v.base; nb = 0; seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      if (busy) begin
        if (nb < LN) begin
          chk("addr", 128'(mem_addr), 128'(ea));
          ea_last = ea;
          ea = ea + v.strd;
        end else begin
          chk("addr_hold", 128'(mem_addr), 128'(ea_last));
        end
        chk("wren", 128'(mem_wren), 128'(v.m));
        if (v.m && nb < LN) chk("wdata", 128'(mem_wdata), 128'(v.vin[nb*16 +: 16]));
        chk("vout_stable", vec_out, cur_exp);
        nb++;
        if (disturb && nb == 3) begin
          start = 1'b1; base_addr = 16'h0500; stride = 16'd7; vec_in = '1; mode = ~v.m;
        end
        if (disturb && nb == 5) start = 1'b0;
      end else if (done) begin
        seen = 1'b1;
        chk("done_wren", 128'(mem_wren), 128'(0));
      end
    end
    chk("done_seen", 128'(seen), 128'(1));
    chk("busy_len", 128'(nb), v.m ? 128'(LN) : 128'(LN + 1));
    chk("vout", vec_out, v.exp_vout);
    chk("ram", 128'(ram[v.chk_a]), 128'(v.chk_d));
    cur_exp = v.exp_vout;
  endtask

  task automatic wait_done(input string n);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk(n, 128'(seen), 128'(1));
  endtask

  initial begin
    int g;
    for (int i = 0; i < 65536; i++) ram[i] <= 16'hDEAD;
    for (int i = 0; i < 8; i++) ram[16'h0010 + i] <= 16'h1000 + 16'(i);
    ram[16'hFFFE] <= 16'hBEEF;
    ram[16'hFFFF] <= 16'hCAFE;
    for (int i = 0; i < 6; i++) ram[i] <= 16'h0C00 + 16'(i);

    tbl[0] = '{1'b0, 16'h0010, 16'd1, 128'h0,
               128'h1007_1006_1005_1004_1003_1002_1001_1000, 16'h0017, 16'h1007};
    tbl[1] = '{1'b1, 16'h0020, 16'd2, 128'hA007_A006_A005_A004_A003_A002_A001_A000,
               128'h1007_1006_1005_1004_1003_1002_1001_1000, 16'h002E, 16'hA007};
    tbl[2] = '{1'b0, 16'h0020, 16'd2, 128'h0,
               128'hA007_A006_A005_A004_A003_A002_A001_A000, 16'h0022, 16'hA001};
    tbl[3] = '{1'b0, 16'hFFFE, 16'd1, 128'h0,
               128'h0C05_0C04_0C03_0C02_0C01_0C00_CAFE_BEEF, 16'hFFFF, 16'hCAFE};
    tbl[4] = '{1'b1, 16'h0040, 16'd0, 128'h0700_0600_0500_0400_0300_0200_0100_0000,
               128'h0C05_0C04_0C03_0C02_0C01_0C00_CAFE_BEEF, 16'h0040, 16'h0700};
    tbl[5] = '{1'b0, 16'h0040, 16'd0, 128'h0,
               128'h0700_0700_0700_0700_0700_0700_0700_0700, 16'h0040, 16'h0700};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_wren", 128'(mem_wren), 128'(0));
    chk("rst_addr", 128'(mem_addr), 128'(0));
    chk("rst_wdata", 128'(mem_wdata), 128'(0));
    chk("rst_vout", vec_out, 128'(0));
    reset = 1'b1;

    for (int i = 0; i < 6; i++) run_op(tbl[i], 1'b0);

    // start and inputs disturbed mid-operation
    run_op(tbl[0], 1'b1);

    // start held high: next op begins two cycles after done
    @(negedge clk);
    start = 1'b1; mode = 1'b0; base_addr = 16'h0020; stride = 16'd2; vec_in = '0;
    wait_done("b2b_done1");
    g = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      g++;
      if (busy) break;
    end
    chk("b2b_gap", 128'(g), 128'(2));
    start = 1'b0;
    wait_done("b2b_done2");
    chk("b2b_vout", vec_out, tbl[2].exp_vout);
    cur_exp = tbl[2].exp_vout;

    // Reset during a load at k = 3
    @(negedge clk);
    start = 1'b1; mode = 1'b0; base_addr = 16'h0010; stride = 16'd1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_done", 128'(done), 128'(0));
    chk("abort_wren", 128'(mem_wren), 128'(0));
    chk("abort_addr", 128'(mem_addr), 128'(0));
    chk("abort_vout", vec_out, 128'(0));
    cur_exp = '0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("abort_idle", 128'(busy), 128'(0));
    run_op(tbl[0], 1'b0);

    // Reset during a store at k = 3: lanes 0..2 written, lane 3 never
    @(negedge clk);
    start = 1'b1; mode = 1'b1; base_addr = 16'h0060; stride = 16'd1;
    vec_in = 128'h5557_5556_5555_5554_5553_5552_5551_5550;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("st_abort_w2", 128'(ram[16'h0062]), 128'(16'h5552));
    chk("st_abort_w3", 128'(ram[16'h0063]), 128'(16'hDEAD));
    chk("st_abort_vout", vec_out, 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vector_mem_unit.md
Name: vector_mem_unit

Overview:
Multi-cycle vector load/store engine between the scalar 16-bit data RAM port and the vector register file. It generalises the fixed 8x16 memory loader:
- lane count, lane width and address width are parameters;
- supports strided addressing;
- supports a store mode;
- uses a start/busy/done handshake.
Sits in the memory stage. It drives the RAM port while busy, and its wide result feeds the vector writeback path.

Parameters:
DATA_W, 16, width of one lane and of a RAM word
LANES, 8, number of lanes per vector (>=2)
ADDR_W, 16, RAM address width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  request; sampled only in IDLE
mode  in  1  0 = load, 1 = store; sampled with start
base_addr  in  ADDR_W  address of lane 0; sampled with start
stride  in  ADDR_W  address increment between lanes; sampled with start
vec_in  in  LANES*DATA_W  store data, lane k at bits [k*DATA_W +: DATA_W]; sampled with start
mem_rdata  in  DATA_W  RAM q; valid the cycle after the address is presented (registered-address RAM)
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_wren  out  1  RAM write enable
vec_out  out  LANES*DATA_W  last completed load result, same lane packing as vec_in
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE;
  - busy, done, mem_wren = 0;
  - mem_addr, mem_wdata = 0;
  - vec_out, staging buffer, latched vec_in, lane counter = 0.
- Reset mid-operation: the operation is aborted with no partial vec_out update; no further RAM writes occur after reset asserts.
- States: IDLE, LD, LD_LAST, ST, DONE.
- IDLE:
  - busy = 0, mem_wren = 0, mem_addr = 0.
  - At an edge with start = 1: latch mode, base_addr, stride and vec_in; set lane counter k = 0 and current address = base_addr.
  - Go to LD (mode = 0) or ST (mode = 1).
- Address generation:
  - Accumulator: addr(k+1) = addr(k) + stride, modulo 2^ADDR_W (wraps silently; no multiplier).
  - stride = 0 is legal: every lane uses the same address.
- LD (LANES cycles, k = 0..LANES-1):
  - mem_addr = addr(k), mem_wren = 0.
  - At the end of each cycle with k >= 1, staging lane k-1 <= mem_rdata.
  - After k = LANES-1, go to LD_LAST.
- LD_LAST (1 cycle):
  - mem_addr holds the last address.
  - At the end of the cycle: staging lane LANES-1 <= mem_rdata, then vec_out <= the full staging vector (atomic update), then go to DONE.
- vec_out never shows a partially loaded vector; it changes only on the LD_LAST -> DONE edge.
- ST (LANES cycles, k = 0..LANES-1):
  - mem_addr = addr(k), mem_wdata = latched lane k, mem_wren = 1.
  - After k = LANES-1, go to DONE.
  - vec_out is unchanged by stores.
- DONE (1 cycle): done = 1, busy = 0, mem_wren = 0; next state IDLE.
- busy = 1 exactly in LD, LD_LAST and ST.
  - Load: busy for LANES+1 cycles.
  - Store: busy for LANES cycles.
  - done follows the last busy cycle.
- start is ignored in every state except IDLE; no queuing.
- start held high continuously gives back-to-back operations separated by DONE plus one IDLE cycle.
- Changes on vec_in, base_addr, stride or mode after acceptance have no effect on the operation in progress.
- mem_wren is 1 only in ST; it is never 1 in LD, LD_LAST, DONE or IDLE.

Test Plan:
1. Load, base 0x0010, stride 1, RAM[0x10+k] = 0x1000+k:
   - mem_addr goes 0x10..0x17 on 8 consecutive cycles;
   - busy is high for 9 cycles, then a done pulse;
   - vec_out = {0x1007,...,0x1000} (lane 0 at LSB);
   - mem_wren never goes high.
2. Store, base 0x0020, stride 2, vec_in lane k = 0xA000+k:
   - writes at 0x20, 0x22, ..., 0x2E on 8 consecutive cycles with matching data;
   - busy is high for 8 cycles, then done;
   - a following load with the same base and stride returns an identical vec_out.
3. Wrap-around, load with base 0xFFFE, stride 1:
   - addresses go 0xFFFE, 0xFFFF, 0x0000, ..., 0x0005;
   - lanes match RAM contents at those addresses.
4. Store with stride 0, base 0x0040, vec_in lane k = 0x0100*k:
   - 8 writes, all to 0x0040;
   - RAM[0x40] ends at 0x0700.
5. start pulsed while busy, and vec_in/base_addr changed mid-operation:
   - start is ignored;
   - the operation completes with the originally latched values;
   - start held high gives a second operation beginning 2 cycles after done.
6. Load with vec_out preloaded to a known pattern, reset driven low during LD at k = 3:
   - busy, done, mem_wren and vec_out go to 0 immediately;
   - after reset is released the unit is in IDLE;
   - a new load completes normally.
